// File: rtl/multi_edge_pulser.sv
// multi_edge_pulser
//   Multi-channel edge-to-pulse converter. Each channel can pass its level
//   input through an optional synchroniser. It then detects rising, falling
//   or both edges, stretches every detected edge into a PULSE_LEN-cycle
//   pulse, and counts the events in a saturating counter that has a sticky
//   overflow flag.
//
// Ports
//   clk           sole clock, rising edge
//   reset         asynchronous active-low reset
//   enable        global detection enable (pulses in flight still complete)
//   signals_in    [CHANNELS]               level inputs, bit i = channel i
//   edge_mode     [2*CHANNELS]             per-channel mode: 00 off, 01 rise,
//                                          10 fall, 11 both
//   count_clear   [CHANNELS]               synchronous clear of counter/overflow
//   pulses        [CHANNELS]               registered event pulses
//   any_pulse                              OR of pulses
//   event_counts  [CHANNELS*COUNT_WIDTH]   channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
//   overflow      [CHANNELS]               sticky counter overflow flags
module multi_edge_pulser #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 1,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [CHANNELS-1:0]             signals_in,
    input  logic [2*CHANNELS-1:0]           edge_mode,
    input  logic [CHANNELS-1:0]             count_clear,
    output logic [CHANNELS-1:0]             pulses,
    output logic                            any_pulse,
    output logic [CHANNELS*COUNT_WIDTH-1:0] event_counts,
    output logic [CHANNELS-1:0]             overflow
);

    localparam logic [7:0]             LP_LEN     = 8'(PULSE_LEN);
    localparam logic [COUNT_WIDTH-1:0] LP_CNT_ONE = COUNT_WIDTH'(1);

    logic [CHANNELS-1:0]    w_s;
    logic [CHANNELS-1:0]    w_rise;
    logic [CHANNELS-1:0]    w_fall;
    logic [CHANNELS-1:0]    w_det;
    logic [7:0]             w_stretch_nxt [CHANNELS];

    logic [CHANNELS-1:0]    r_prev;
    logic [7:0]             r_stretch [CHANNELS];
    logic [CHANNELS-1:0]    r_pulses;
    logic [COUNT_WIDTH-1:0] r_count [CHANNELS];
    logic [CHANNELS-1:0]    r_ovf;

    // Synchroniser: the last stage is the detection point w_s.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = signals_in;
        end else begin : g_sync
            logic [CHANNELS-1:0] r_sync [SYNC_STAGES];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= '0;
                    end
                end else begin
                    r_sync[0] <= signals_in;
                    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= r_sync[k-1];
                    end
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // History keeps tracking while disabled so re-enabling sees no stale edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_s;
        end
    end

    assign w_rise = w_s & ~r_prev;
    assign w_fall = ~w_s & r_prev;

    always_comb begin
        w_det = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_det[i] = enable & ((edge_mode[2*i] & w_rise[i]) |
                                 (edge_mode[2*i+1] & w_fall[i]));
        end
    end

    // Stretch: a retrigger reloads the full length, so overlapping events merge.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_stretch_nxt[i] = '0;
            if (w_det[i]) begin
                w_stretch_nxt[i] = LP_LEN;
            end else if (r_stretch[i] != '0) begin
                w_stretch_nxt[i] = r_stretch[i] - 8'd1;
            end
        end
    end

    // The pulse flop is loaded from the next stretch value, so pulses[i]
    // equals (stretch != 0) while still coming straight from a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                r_stretch[i] <= '0;
            end
            r_pulses <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                r_stretch[i] <= w_stretch_nxt[i];
                r_pulses[i]  <= (w_stretch_nxt[i] != '0);
            end
        end
    end

    // Saturating counters; a clear coinciding with a detect counts that event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                r_count[i] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (count_clear[i]) begin
                    r_count[i] <= w_det[i] ? LP_CNT_ONE : '0;
                    r_ovf[i]   <= 1'b0;
                end else if (w_det[i]) begin
                    if (r_count[i] == '1) begin
                        r_ovf[i] <= 1'b1;
                    end else begin
                        r_count[i] <= r_count[i] + LP_CNT_ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        event_counts = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            event_counts[i*COUNT_WIDTH +: COUNT_WIDTH] = r_count[i];
        end
    end

    assign pulses    = r_pulses;
    assign any_pulse = |r_pulses;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_multi_edge_pulser.sv
// Bench for multi_edge_pulser. Three instances share one stimulus:
//   A: SYNC 2, PULSE_LEN 1, COUNT_WIDTH 8
//   B: SYNC 0, PULSE_LEN 4, COUNT_WIDTH 2
//   C: SYNC 1, PULSE_LEN 3, COUNT_WIDTH 4
// A reference model tracks each instance at every clock.
module tb_multi_edge_pulser;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  sig_in;
    logic [7:0]  mode;
    logic [3:0]  clr;

    logic [3:0]  pA, pB, pC;
    logic        anyA, anyB, anyC;
    logic [31:0] cA;
    logic [7:0]  cB;
    logic [15:0] cC;
    logic [3:0]  oA, oB, oC;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    multi_edge_pulser #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(1), .COUNT_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .signals_in(sig_in), .edge_mode(mode),
        .count_clear(clr), .pulses(pA), .any_pulse(anyA), .event_counts(cA), .overflow(oA));

    multi_edge_pulser #(.CHANNELS(4), .SYNC_STAGES(0), .PULSE_LEN(4), .COUNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .signals_in(sig_in), .edge_mode(mode),
        .count_clear(clr), .pulses(pB), .any_pulse(anyB), .event_counts(cB), .overflow(oB));

    multi_edge_pulser #(.CHANNELS(4), .SYNC_STAGES(1), .PULSE_LEN(3), .COUNT_WIDTH(4)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .signals_in(sig_in), .edge_mode(mode),
        .count_clear(clr), .pulses(pC), .any_pulse(anyC), .event_counts(cC), .overflow(oC));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Input samples taken at each clock; the detection point of an instance
    // with k synchroniser stages sees the sample from k clocks earlier.
    bit [3:0] hq[$];
    int       rem [3][4];
    int       cnt [3][4];
    bit       ovm [3][4];

    function automatic int syn_of(int d);
        return (d == 0) ? 2 : (d == 1) ? 0 : 1;
    endfunction
    function automatic int len_of(int d);
        return (d == 0) ? 1 : (d == 1) ? 4 : 3;
    endfunction
    function automatic int cw_of(int d);
        return (d == 0) ? 8 : (d == 1) ? 2 : 4;
    endfunction

    function automatic void model_reset();
        hq.delete();
        for (int j = 0; j < 6; j++) hq.push_back(4'b0000);
        for (int d = 0; d < 3; d++)
            for (int ch = 0; ch < 4; ch++) begin
                rem[d][ch] = 0;
                cnt[d][ch] = 0;
                ovm[d][ch] = 1'b0;
            end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_reset();
        end else begin
            for (int d = 0; d < 3; d++) begin
                bit [3:0] sv, pv;
                int k, maxv;
                k    = syn_of(d);
                maxv = (1 << cw_of(d)) - 1;
                sv   = (k == 0) ? sig_in : hq[hq.size() - k];
                pv   = hq[hq.size() - 1 - k];
                for (int ch = 0; ch < 4; ch++) begin
                    bit det;
                    det = enable && ((mode[2*ch] && sv[ch] && !pv[ch]) ||
                                     (mode[2*ch+1] && !sv[ch] && pv[ch]));
                    if (det) rem[d][ch] = len_of(d);
                    else if (rem[d][ch] > 0) rem[d][ch] = rem[d][ch] - 1;
                    if (clr[ch]) begin
                        cnt[d][ch] = det ? 1 : 0;
                        ovm[d][ch] = 1'b0;
                    end else if (det) begin
                        if (cnt[d][ch] == maxv) ovm[d][ch] = 1'b1;
                        else cnt[d][ch] = cnt[d][ch] + 1;
                    end
                end
            end
            hq.push_back(sig_in);
            void'(hq.pop_front());
        end
    end

    function automatic logic [3:0] exp_p(int d);
        logic [3:0] v = '0;
        for (int ch = 0; ch < 4; ch++) v[ch] = (rem[d][ch] != 0);
        return v;
    endfunction
    function automatic logic [3:0] exp_o(int d);
        logic [3:0] v = '0;
        for (int ch = 0; ch < 4; ch++) v[ch] = ovm[d][ch];
        return v;
    endfunction
    function automatic logic [63:0] exp_c(int d);
        logic [63:0] v = '0;
        for (int ch = 0; ch < 4; ch++) v = v | (64'(cnt[d][ch]) << (ch * cw_of(d)));
        return v;
    endfunction

    always @(negedge clk) begin
        check("mdl_pulses_A", 64'(pA), 64'(exp_p(0)));
        check("mdl_any_A",    64'(anyA), 64'(|exp_p(0)));
        check("mdl_counts_A", 64'(cA), exp_c(0));
        check("mdl_ovf_A",    64'(oA), 64'(exp_o(0)));
        check("mdl_pulses_B", 64'(pB), 64'(exp_p(1)));
        check("mdl_any_B",    64'(anyB), 64'(|exp_p(1)));
        check("mdl_counts_B", 64'(cB), exp_c(1));
        check("mdl_ovf_B",    64'(oB), 64'(exp_o(1)));
        check("mdl_pulses_C", 64'(pC), 64'(exp_p(2)));
        check("mdl_any_C",    64'(anyC), 64'(|exp_p(2)));
        check("mdl_counts_C", 64'(cC), exp_c(2));
        check("mdl_ovf_C",    64'(oC), 64'(exp_o(2)));
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic [3:0]  in;
        logic [7:0]  md;
        int          n;
        logic [3:0]  exp_p;
        logic [31:0] exp_c;
    } vec_t;

    vec_t tbl [9];

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        sig_in = 4'b0000;
        clr    = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // Release at E(-1)/E0 boundary, ch0 high before E0; A has 2 sync stages.
        tbl[0] = '{4'b0001, 8'h55, 2, 4'b0000, 32'h0000_0000};
        tbl[1] = '{4'b0001, 8'h55, 1, 4'b0001, 32'h0000_0001};
        tbl[2] = '{4'b0001, 8'h55, 1, 4'b0000, 32'h0000_0001};
        tbl[3] = '{4'b1111, 8'h39, 2, 4'b0000, 32'h0000_0001};
        tbl[4] = '{4'b1111, 8'h39, 1, 4'b0100, 32'h0001_0001};
        tbl[5] = '{4'b1111, 8'h39, 7, 4'b0000, 32'h0001_0001};
        tbl[6] = '{4'b0001, 8'h39, 2, 4'b0000, 32'h0001_0001};
        tbl[7] = '{4'b0001, 8'h39, 1, 4'b0110, 32'h0002_0101};
        tbl[8] = '{4'b0001, 8'h39, 1, 4'b0000, 32'h0002_0101};

        reset  = 1'b1;
        enable = 1'b1;
        sig_in = 4'b0000;
        mode   = 8'h55;
        clr    = 4'b0000;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pulses", 64'(pA), 64'd0);
        check("rst_any",    64'(anyA), 64'd0);
        check("rst_counts", 64'(cA), 64'd0);
        check("rst_ovf",    64'(oA), 64'd0);

        // Reset release and mode coverage (instance A).
        reset = 1'b1;
        for (int r = 0; r < 9; r++) begin
            sig_in = tbl[r].in;
            mode   = tbl[r].md;
            repeat (tbl[r].n) @(negedge clk);
            check($sformatf("tbl%0d_pulses", r), 64'(pA), 64'(tbl[r].exp_p));
            check($sformatf("tbl%0d_any", r), 64'(anyA), 64'(|tbl[r].exp_p));
            check($sformatf("tbl%0d_counts", r), 64'(cA), 64'(tbl[r].exp_c));
        end

        // Stretch and retrigger (instance B): rises at E0 and E2, 6-cycle pulse.
        mode = 8'h55;
        do_reset();
        sig_in = 4'b0001; @(negedge clk); check("stretch_e0", 64'(pB[0]), 64'd1);
        sig_in = 4'b0000; @(negedge clk); check("stretch_e1", 64'(pB[0]), 64'd1);
        sig_in = 4'b0001; @(negedge clk); check("stretch_e2", 64'(pB[0]), 64'd1);
        for (int e = 3; e <= 6; e++) begin
            @(negedge clk);
            check($sformatf("stretch_e%0d", e), 64'(pB[0]), 64'(e <= 5));
        end
        check("stretch_count", 64'(cB[1:0]), 64'd2);

        // Saturation and clear (instance B, 2-bit counter).
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            sig_in = 4'b0001; @(negedge clk);
            check($sformatf("sat_count%0d", k), 64'(cB[1:0]), 64'((k > 3) ? 3 : k));
            check($sformatf("sat_ovf%0d", k), 64'(oB[0]), 64'(k >= 4));
            sig_in = 4'b0000; @(negedge clk);
        end
        sig_in = 4'b0001; clr = 4'b0001; @(negedge clk);
        check("clr_det_count", 64'(cB[1:0]), 64'd1);
        check("clr_det_ovf",   64'(oB[0]), 64'd0);
        @(negedge clk);
        check("clr_only_count", 64'(cB[1:0]), 64'd0);
        clr = 4'b0000;

        // Enable gating: a level raised while disabled makes no event later.
        do_reset();
        enable = 1'b0;
        sig_in = 4'b0001;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            check($sformatf("en_gate_C%0d", e), 64'(pC[0]), 64'd0);
            check($sformatf("en_gate_A%0d", e), 64'(pA[0]), 64'd0);
        end
        check("en_gate_countC", 64'(cC[3:0]), 64'd0);
        // Pulse in flight completes after enable drops (C: 1 sync stage, len 3).
        sig_in = 4'b0011; @(negedge clk); check("en_run0", 64'(pC[1]), 64'd0);
        @(negedge clk); check("en_run1", 64'(pC[1]), 64'd1);
        enable = 1'b0;
        @(negedge clk); check("en_run2", 64'(pC[1]), 64'd1);
        @(negedge clk); check("en_run3", 64'(pC[1]), 64'd1);
        @(negedge clk); check("en_run4", 64'(pC[1]), 64'd0);
        check("en_run_count", 64'(cC[7:4]), 64'd1);

        // Async reset mid-pulse with B overflowed on ch2.
        enable = 1'b1;
        sig_in = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            sig_in = 4'b0100; @(negedge clk);
            sig_in = 4'b0000; @(negedge clk);
        end
        sig_in = 4'b0001; @(negedge clk);
        check("pre_rst_pulse", 64'(pB[0]), 64'd1);
        check("pre_rst_ovf",   64'(oB[2]), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_pulsesB", 64'(pB), 64'd0);
        check("arst_anyB",    64'(anyB), 64'd0);
        check("arst_countsB", 64'(cB), 64'd0);
        check("arst_ovfB",    64'(oB), 64'd0);
        check("arst_countsC", 64'(cC), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            check($sformatf("rel_A_e%0d", e), 64'(pA[0]), 64'(e == 3));
            check($sformatf("rel_B_e%0d", e), 64'(pB[0]), 64'(e >= 1 && e <= 4));
            check($sformatf("rel_C_e%0d", e), 64'(pC[0]), 64'(e >= 2 && e <= 4));
        end

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            sig_in = sig_in ^ (4'($urandom) & 4'($urandom));
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
            enable = ($urandom_range(0, 7) != 0);
            clr    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            if (c == 200) begin
                #2 reset = 1'b0;
                #1 reset = 1'b1;
            end
            @(negedge clk);
        end

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/multi_edge_pulser.md
# multi_edge_pulser

Parametrised, multi-channel successor to the single-channel posedge pulser. It converts slow or asynchronous level inputs into pulses one `clk` cycle wide, or `PULSE_LEN` cycles wide, on `clk`. Features:
- optional input synchronisation;
- per-channel edge mode selection: rising, falling or both;
- per-channel saturating event counters.

It sits between divided-clock or switch/sensor sources and the control FSMs that consume single-cycle events.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent input channels (1..32).
- `SYNC_STAGES`, 2: flip-flop synchroniser depth per channel (0..4; 0 = input used directly).
- `PULSE_LEN`, 1: output pulse width in `clk` cycles (1..255).
- `COUNT_WIDTH`, 8: width of each per-channel event counter (1..16).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global detection enable.
- `signals_in`  in  CHANNELS  level inputs; bit i is channel i.
- `edge_mode`  in  2*CHANNELS  bits [2i+1:2i] set channel i's mode: 00 off, 01 rising, 10 falling, 11 both.
- `count_clear`  in  CHANNELS  per-channel synchronous clear of counter and overflow.
- `pulses`  out  CHANNELS  per-channel event pulse.
- `any_pulse`  out  1  OR of all `pulses`.
- `event_counts`  out  CHANNELS*COUNT_WIDTH  channel i at bits [(i+1)*COUNT_WIDTH-1 : i*COUNT_WIDTH].
- `overflow`  out  CHANNELS  sticky per-channel counter overflow flag.

## Operation
Per channel:
- Synchroniser chain of `SYNC_STAGES` flops. Its last stage is `s`. When `SYNC_STAGES` = 0, `s` = `signals_in[i]`.
- History flop `prev` <= `s` every cycle, regardless of `enable` or mode.
- Combinational detect (all terms ANDed with `enable`):
  - rise = `s & ~prev`
  - fall = `~s & prev`
  - `det` = (mode[0] & rise) | (mode[1] & fall)
  - Mode 00 never detects.
- Stretch counter, 8 bits:
  - On `det`, load `PULSE_LEN`; otherwise decrement if nonzero.
  - `pulses[i]` = stretch counter != 0, driven directly from a register.
  - A retrigger while the pulse is active reloads `PULSE_LEN`, which extends the pulse. Overlapping events do not produce a gap.
- Event counter:
  - On `det`, increment by 1 if below the all-ones value.
  - If already all-ones, hold all-ones and set `overflow[i]`.
  - `count_clear[i]`: the counter goes to 0 and `overflow[i]` to 0. If `det` occurs in the same cycle, the counter goes to 1 and `overflow` to 0.
- `enable` low:
  - No new detections.
  - Pulses already in progress run to completion.
  - The synchroniser and `prev` keep tracking, so re-enabling never creates a spurious edge for a level that changed while disabled.
- `edge_mode` changes take effect on the same cycle's detect, since detect is combinational on the mode.
- `any_pulse` is the combinational OR of the registered `pulses`.

## Timing
Reset:
- While `reset` = 0, all synchroniser flops, `prev`, stretch counters, `event_counts`, `overflow`, `pulses` and `any_pulse` are 0, asynchronously.
- Because `prev` resets to 0, an input held high through reset release yields one rising-edge event once synchronised, provided the channel is in mode 01 or 11.

Latency:
- A new level must be stable before rising edge E0.
- `pulses[i]` rises after edge E0+`SYNC_STAGES`.
- The counter increments on that same edge.
- `SYNC_STAGES`=0: the pulse appears after E0.

Width:
- Exactly `PULSE_LEN` cycles for an isolated event.
- Retriggering at cycle k of an active pulse gives a total width of k+`PULSE_LEN`.

Throughput:
- An input toggling every cycle in mode 11 detects every cycle.
- `pulses` then stays high continuously, and the counter increments every cycle.

Reset asserted mid-pulse clears the pulse immediately. No event is generated on release unless an input is high and the channel is in a rising mode.

## Test plan
- Reset release: `CHANNELS`=4, `SYNC_STAGES`=2, `PULSE_LEN`=1, all modes 01, all inputs low.
  - Required: all outputs 0.
  - Drive ch0 high before E0. Required: `pulses`=4'b0001 after E2, for exactly one cycle; `event_counts` ch0 = 1; `any_pulse` is high for that cycle.
- Mode coverage: ch1 in mode 10, ch2 in mode 11, ch3 in mode 00, each toggled high then low 10 cycles apart.
  - Required counts: ch1 = 1, ch2 = 2, ch3 = 0.
  - Pulses appear only on the matching edges.
- Stretch and retrigger: `PULSE_LEN`=4, rising edges 2 cycles apart.
  - Required: a single continuous pulse 6 cycles wide; count = 2.
- Saturation and clear: `COUNT_WIDTH`=2, 5 rising edges.
  - Required: count sequence 1,2,3,3,3; `overflow` set on the 4th edge.
  - `count_clear` in the same cycle as a detect. Required: count = 1, `overflow` = 0.
- Enable gating:
  - Raise ch0 while `enable`=0, then set `enable`=1. Required: no pulse, count unchanged.
  - Raise ch0 with enable high and a pulse active (`PULSE_LEN`=3), then drop `enable`. Required: the pulse completes all 3 cycles.
- Async reset mid-pulse: assert `reset`=0 between clock edges during an active pulse.
  - Required: `pulses`, counters and `overflow` drop to 0 immediately, without waiting for `clk`.
  - With ch0 held high through reset release: exactly one pulse, `SYNC_STAGES`+1 edges later.
